jtag_dbg_master: RTL and testbench

//  Debug-side initiator for the core's debug register/halt port (jtag_reg_* + jtag_halt_flag).

---
 rtl/jtag_dbg_master_pkg.sv | 23 ++
 rtl/jtag_dbg_settle_cnt.sv | 43 ++++
 rtl/jtag_dbg_master.sv | 218 +++++++++++++++++++++
 tb/tb_jtag_dbg_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_dbg_master_pkg.sv
// Shared opcode/state encodings for the debug master.
// Build option JTAG_DBG_AUTOHALT_EN is consumed by jtag_dbg_master.sv.
package jtag_dbg_master_pkg;

  localparam int DBG_STATE_WIDTH = 3;

  localparam logic [1:0] DBG_OP_STATUS = 2'b00;
  localparam logic [1:0] DBG_OP_GPR_RD = 2'b01;
  localparam logic [1:0] DBG_OP_GPR_WR = 2'b10;
  localparam logic [1:0] DBG_OP_CTRL   = 2'b11;

  localparam logic [DBG_STATE_WIDTH-1:0] ST_IDLE      = 3'd0;
  localparam logic [DBG_STATE_WIDTH-1:0] ST_HALT_WAIT = 3'd1;
  localparam logic [DBG_STATE_WIDTH-1:0] ST_ACCESS    = 3'd2;
  localparam logic [DBG_STATE_WIDTH-1:0] ST_CAPTURE   = 3'd3;
  localparam logic [DBG_STATE_WIDTH-1:0] ST_RESUME    = 3'd4;
  localparam logic [DBG_STATE_WIDTH-1:0] ST_RESP      = 3'd5;

  function automatic int settle_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/jtag_dbg_settle_cnt.sv
// Halt settle counter: loads the settle length, counts down to zero and
// flags the step that will reach zero.
module jtag_dbg_settle_cnt
  import jtag_dbg_master_pkg::*;
#(
  parameter int LOAD_VAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  localparam int CNT_W = settle_cnt_width(LOAD_VAL);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(LOAD_VAL);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/jtag_dbg_master.sv
// Debug-side initiator for the core GPR/halt port: one command in flight, one response each.
// Build option JTAG_DBG_AUTOHALT_EN: GPR access while running halts, accesses, then resumes.
module jtag_dbg_master
  import jtag_dbg_master_pkg::*;
#(
  parameter int HALT_SETTLE_CYCLES = 4,
  parameter int ADDR_W             = 5,
  parameter int DATA_W             = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_req_valid_i,
  output logic              dbg_req_ready_o,
  input  logic [1:0]        dbg_req_op_i,
  input  logic [ADDR_W-1:0] dbg_req_addr_i,
  input  logic [DATA_W-1:0] dbg_req_data_i,
  output logic              dbg_resp_valid_o,
  input  logic              dbg_resp_ready_i,
  output logic [DATA_W-1:0] dbg_resp_data_o,
  output logic              dbg_resp_err_o,
  output logic [ADDR_W-1:0] jtag_reg_addr_o,
  output logic [DATA_W-1:0] jtag_reg_data_o,
  output logic              jtag_reg_we_o,
  input  logic [DATA_W-1:0] jtag_reg_data_i,
  output logic              jtag_halt_flag_o,
  output logic              halted_o
);

  logic [DBG_STATE_WIDTH-1:0] state_q, state_d;
  logic [1:0]                 op_q, op_d;
  logic                       auto_q, auto_d;
  logic                       ready_q, ready_d;
  logic                       resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]          resp_data_q, resp_data_d;
  logic                       resp_err_q, resp_err_d;
  logic [ADDR_W-1:0]          reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]          reg_data_q, reg_data_d;
  logic                       reg_we_q, reg_we_d;
  logic                       halt_q, halt_d;
  logic                       halted_q, halted_d;
  logic                       cnt_load_s, cnt_dec_s, cnt_last_s;

  jtag_dbg_settle_cnt #(.LOAD_VAL(HALT_SETTLE_CYCLES)) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load_s),
    .dec_i  (cnt_dec_s),
    .last_o (cnt_last_s)
  );

  // Command sequencer: next state, response and core-port values.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    auto_d       = auto_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    reg_addr_d   = reg_addr_q;
    reg_data_d   = reg_data_q;
    reg_we_d     = 1'b0;
    halt_d       = halt_q;
    halted_d     = halted_q;
    cnt_load_s   = 1'b0;
    cnt_dec_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dbg_req_valid_i && ready_q) begin
          op_d        = dbg_req_op_i;
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          case (dbg_req_op_i)
            DBG_OP_STATUS: begin
              resp_data_d  = {{(DATA_W-1){1'b0}}, halted_q};
              resp_valid_d = 1'b1;
              state_d      = ST_RESP;
            end
            DBG_OP_CTRL: begin
              if (dbg_req_data_i[0] && !halted_q) begin
                halt_d     = 1'b1;
                cnt_load_s = 1'b1;
                state_d    = ST_HALT_WAIT;
              end else if (dbg_req_data_i[0]) begin
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
              end else begin
                halt_d       = 1'b0;
                halted_d     = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
              end
            end
            DBG_OP_GPR_RD, DBG_OP_GPR_WR: begin
              if (halted_q) begin
                reg_addr_d = dbg_req_addr_i;
                reg_data_d = (dbg_req_op_i == DBG_OP_GPR_WR) ? dbg_req_data_i : reg_data_q;
                reg_we_d   = (dbg_req_op_i == DBG_OP_GPR_WR) && (dbg_req_addr_i != '0);
                state_d    = ST_ACCESS;
              end else begin
`ifdef JTAG_DBG_AUTOHALT_EN
                reg_addr_d = dbg_req_addr_i;
                reg_data_d = (dbg_req_op_i == DBG_OP_GPR_WR) ? dbg_req_data_i : reg_data_q;
                auto_d     = 1'b1;
                halt_d     = 1'b1;
                cnt_load_s = 1'b1;
                state_d    = ST_HALT_WAIT;
`else
                resp_err_d   = 1'b1;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
`endif
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT_WAIT: begin
        cnt_dec_s = 1'b1;
        // Halt is reported on the step that takes the counter from 1 to 0.
        if (halt_q && cnt_last_s) begin
          halted_d = 1'b1;
          if (op_q == DBG_OP_CTRL) begin
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end else begin
            reg_we_d = (op_q == DBG_OP_GPR_WR) && (reg_addr_q != '0);
            state_d  = ST_ACCESS;
          end
        end else begin
          state_d = ST_HALT_WAIT;
        end
      end
      ST_ACCESS: begin
        if (op_q == DBG_OP_GPR_RD) begin
          state_d = ST_CAPTURE;
        end else if (auto_q) begin
          halt_d   = 1'b0;
          halted_d = 1'b0;
          state_d  = ST_RESUME;
        end else begin
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_CAPTURE: begin
        resp_data_d = (reg_addr_q == '0) ? '0 : jtag_reg_data_i;
        if (auto_q) begin
          halt_d   = 1'b0;
          halted_d = 1'b0;
          state_d  = ST_RESUME;
        end else begin
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESUME: begin
        auto_d       = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (dbg_resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      op_q         <= 2'b00;
      auto_q       <= 1'b0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      reg_addr_q   <= '0;
      reg_data_q   <= '0;
      reg_we_q     <= 1'b0;
      halt_q       <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      auto_q       <= auto_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
      reg_we_q     <= reg_we_d;
      halt_q       <= halt_d;
      halted_q     <= halted_d;
    end
  end

  assign dbg_req_ready_o  = ready_q;
  assign dbg_resp_valid_o = resp_valid_q;
  assign dbg_resp_data_o  = resp_data_q;
  assign dbg_resp_err_o   = resp_err_q;
  assign jtag_reg_addr_o  = reg_addr_q;
  assign jtag_reg_data_o  = reg_data_q;
  assign jtag_reg_we_o    = reg_we_q;
  assign jtag_halt_flag_o = halt_q;
  assign halted_o         = halted_q;

endmodule

// File: tb/tb_jtag_dbg_master.sv
// Scoreboard bench for jtag_dbg_master: driver pushes expected responses from a
// command-level model, a monitor pops and checks them; a core GPR stub answers reads.
module tb_jtag_dbg_master;

  localparam int H = 4;
`ifdef JTAG_DBG_AUTOHALT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        halted;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_req_valid_i, dbg_req_ready_o;
  logic [1:0]  dbg_req_op_i;
  logic [4:0]  dbg_req_addr_i;
  logic [31:0] dbg_req_data_i;
  logic        dbg_resp_valid_o, dbg_resp_ready_i, dbg_resp_err_o;
  logic [31:0] dbg_resp_data_o;
  logic [4:0]  jtag_reg_addr_o;
  logic [31:0] jtag_reg_data_o, jtag_reg_data_i;
  logic        jtag_reg_we_o, jtag_halt_flag_o, halted_o;

  exp_t        expq[$];
  logic [36:0] wq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          bp_hold = 1'b0;
  logic        model_halted;
  logic [31:0] model_rf[32];
  logic [31:0] core_rf[32];
  logic        rf_init;

  jtag_dbg_master dut (
    .clk(clk), .rst(rst),
    .dbg_req_valid_i(dbg_req_valid_i), .dbg_req_ready_o(dbg_req_ready_o),
    .dbg_req_op_i(dbg_req_op_i), .dbg_req_addr_i(dbg_req_addr_i), .dbg_req_data_i(dbg_req_data_i),
    .dbg_resp_valid_o(dbg_resp_valid_o), .dbg_resp_ready_i(dbg_resp_ready_i),
    .dbg_resp_data_o(dbg_resp_data_o), .dbg_resp_err_o(dbg_resp_err_o),
    .jtag_reg_addr_o(jtag_reg_addr_o), .jtag_reg_data_o(jtag_reg_data_o),
    .jtag_reg_we_o(jtag_reg_we_o), .jtag_reg_data_i(jtag_reg_data_i),
    .jtag_halt_flag_o(jtag_halt_flag_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rf_seed(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Core GPR file stub.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) core_rf[i] <= rf_seed(i);
    end else if (jtag_reg_we_o) begin
      core_rf[jtag_reg_addr_o] <= jtag_reg_data_o;
    end
  end
  assign jtag_reg_data_i = core_rf[jtag_reg_addr_o];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Command-level reference model: effect on halted/GPRs and response latency.
  task automatic model(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data,
                       output exp_t e);
    e.data = 32'h0; e.err = 1'b0; e.lat = 1; e.acc = 0; e.name = "status";
    case (op)
      2'b00: e.data = {31'h0, model_halted};
      2'b11: begin
        if (data[0]) begin
          e.name = "halt";
          if (!model_halted) e.lat = 1 + H;
          model_halted = 1'b1;
        end else begin
          e.name = "resume";
          model_halted = 1'b0;
        end
      end
      default: begin
        e.name = (op == 2'b10) ? "gpr_wr" : "gpr_rd";
        if (model_halted || AUTO) begin
          if (op == 2'b10) begin
            e.lat = 2;
            if (addr != 5'd0) begin
              model_rf[addr] = data;
              wq.push_back({addr, data});
            end
          end else begin
            e.lat = 3;
            e.data = (addr == 5'd0) ? 32'h0 : model_rf[addr];
          end
          if (!model_halted) e.lat += H + 1;
        end else begin
          e.err = 1'b1;
        end
      end
    endcase
    e.halted = model_halted;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    int   n = 0;
    logic was_halted, exp_flag, exp_hd, exp_we;
    dbg_req_op_i = op; dbg_req_addr_i = addr; dbg_req_data_i = data; dbg_req_valid_i = 1'b1;
    while (!dbg_req_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!dbg_req_ready_o) begin
      total++; bad++;
      $display("FAIL req_accept_timeout: waited %0d cycles, required ready", n);
      dbg_req_valid_i = 1'b0;
      return;
    end
    was_halted = model_halted;
    model(op, addr, data, e);
    e.acc = cyc + 1;
    expq.push_back(e);
    @(negedge clk);
    dbg_req_valid_i = 1'b0;
    exp_flag = (op == 2'b11) ? data[0] : (was_halted || (op != 2'b00 && AUTO));
    exp_hd   = (op == 2'b11) ? (data[0] && was_halted) : was_halted;
    exp_we   = (op == 2'b10) && (addr != 5'd0) && was_halted;
    chk({e.name, "_t1_flag_halted_we"}, {jtag_halt_flag_o, halted_o, jtag_reg_we_o},
        {exp_flag, exp_hd, exp_we});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", expq.size());
      expq.delete();
    end
  endtask

  // Response monitor with random and forced backpressure.
  initial begin : monitor
    exp_t        cur;
    bit          seen = 1'b0;
    int          hold = 0;
    logic [32:0] held = '0;
    dbg_resp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && dbg_resp_valid_o) begin
        chk("req_ready_low_while_resp", {63'h0, dbg_req_ready_o}, 64'h0);
        if (!seen) begin
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: data %h err %b, required none", dbg_resp_data_o, dbg_resp_err_o);
          end else begin
            cur = expq[0];
            chk({cur.name, "_data"}, {32'h0, dbg_resp_data_o}, {32'h0, cur.data});
            chk({cur.name, "_err"}, {63'h0, dbg_resp_err_o}, {63'h0, cur.err});
            chk({cur.name, "_latency"}, 64'(cyc - cur.acc + 1), 64'(cur.lat));
            chk({cur.name, "_halted_flag"}, {62'h0, halted_o, jtag_halt_flag_o},
                {62'h0, cur.halted, cur.halted});
          end
          seen = 1'b1;
          held = {dbg_resp_err_o, dbg_resp_data_o};
          hold = bp_hold ? 10 : 0;
        end else begin
          chk("resp_stable", {31'h0, dbg_resp_err_o, dbg_resp_data_o}, {31'h0, held});
        end
        if (hold > 0) begin
          hold--;
          dbg_resp_ready_i = 1'b0;
        end else begin
          dbg_resp_ready_i = ($urandom_range(0, 3) != 0);
        end
        if (dbg_resp_ready_i) begin
          if (expq.size() != 0) void'(expq.pop_front());
          seen = 1'b0;
        end
      end else begin
        seen = 1'b0;
        dbg_resp_ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // Write-strobe monitor: each pulse must match the next expected GPR write.
  always @(negedge clk) begin
    if (rst && jtag_reg_we_o) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_we: addr %0d data %h, required no pulse", jtag_reg_addr_o, jtag_reg_data_o);
      end else begin
        chk("we_addr_data", {27'h0, jtag_reg_addr_o, jtag_reg_data_o}, {27'h0, wq[0]});
        void'(wq.pop_front());
      end
    end
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] d;
    rst = 1'b0; rf_init = 1'b1; model_halted = 1'b0;
    dbg_req_valid_i = 1'b0; dbg_req_op_i = 2'b00; dbg_req_addr_i = 5'd0; dbg_req_data_i = 32'h0;
    for (int i = 0; i < 32; i++) model_rf[i] = rf_seed(i);
    repeat (3) @(negedge clk);
    chk("reset_resp_side", {29'h0, dbg_req_ready_o, dbg_resp_valid_o, dbg_resp_err_o, dbg_resp_data_o}, 64'h0);
    chk("reset_core_side", {24'h0, jtag_reg_addr_o, jtag_reg_data_o, jtag_reg_we_o, jtag_halt_flag_o, halted_o}, 64'h0);
    rf_init = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", {63'h0, dbg_req_ready_o}, 64'h1);

    issue(2'b00, 5'd0, 32'h0);
    issue(2'b11, 5'd0, 32'h1);
    issue(2'b00, 5'd0, 32'h0);
    issue(2'b10, 5'd5, 32'hDEAD_BEEF);
    issue(2'b01, 5'd5, 32'h0);
    issue(2'b10, 5'd0, 32'h1234_5678);
    issue(2'b01, 5'd0, 32'h0);
    issue(2'b11, 5'd0, 32'h1);
    issue(2'b11, 5'd0, 32'h0);
    issue(2'b11, 5'd0, 32'h0);
    issue(2'b01, 5'd7, 32'h0);
    issue(2'b10, 5'd9, 32'h0BAD_F00D);
    issue(2'b01, 5'd9, 32'h0);

    bp_hold = 1'b1;
    issue(2'b00, 5'd0, 32'h0);
    issue(2'b00, 5'd0, 32'h0);
    bp_hold = 1'b0;

    wait_drain();
    issue(2'b11, 5'd0, 32'h0);
    issue(2'b11, 5'd0, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_mid_halt_wait", {61'h0, jtag_halt_flag_o, halted_o, dbg_resp_valid_o}, 64'h0);
    expq.delete();
    model_halted = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    issue(2'b00, 5'd0, 32'h0);

    for (int k = 0; k < 80; k++) begin
      op = 2'($urandom_range(0, 3));
      d = $urandom;
      issue(op, 5'($urandom_range(0, 31)), d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_drain();
    repeat (3) @(negedge clk);
    chk("pending_writes_left", 64'(wq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
